// File: rtl/uart_xfer_ctrl.sv
// rtl/uart_xfer_ctrl.sv - framed packet sequencer driving uart_core: STX, payload, ETX, then ACK wait with ENQ retries
module uart_xfer_ctrl #(
  parameter int DIV_W     = 16,
  parameter int DIV       = 100,
  parameter int LEN_W     = 8,
  parameter int TOUT_W    = 24,
  parameter int TIMEOUT   = 100000,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              pld_valid,
  input  logic [7:0]        pld_data,
  output logic              pld_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic              uart_rst_soft,
  output logic              uart_tx_en,
  output logic              uart_rx_en,
  output logic [DIV_W-1:0]  uart_bit_duration,
  output logic [7:0]        uart_tx_data,
  output logic              uart_data_write_en,
  input  logic              uart_tx_ready,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_ready,
  output logic              uart_data_read_en
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT - 1);
  localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);

  localparam logic [7:0] CH_STX = 8'h02;
  localparam logic [7:0] CH_ETX = 8'h03;
  localparam logic [7:0] CH_EOT = 8'h04;
  localparam logic [7:0] CH_ENQ = 8'h05;
  localparam logic [7:0] CH_ACK = 8'h06;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_SEND_STX,
    S_SEND_DATA,
    S_SEND_ETX,
    S_WAIT_RSP,
    S_SEND_ENQ,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_len_cnt;
  logic [TOUT_W-1:0]  r_timer;
  logic [RW-1:0]      r_retry;
  logic [1:0]         r_err_code;
  logic               r_uart_en;
  logic [1:0]         r_wr_hold;
  logic [1:0]         r_rd_hold;

  logic               w_wr_ok;
  logic               w_rd_ok;
  logic               w_wr;
  logic               w_rd;
  logic [7:0]         w_tx_byte;
  logic               w_pld_rdy;
  logic               w_start_ok;
  logic               w_len_dec;
  logic               w_tmr_clr;
  logic               w_tmr_inc;
  logic               w_retry_inc;
  logic               w_err_set;
  logic [1:0]         w_err_val;

  // uart_core needs two cycles after each strobe before its ready flags are meaningful again
  assign w_wr_ok = uart_tx_ready && (r_wr_hold == 2'd0);
  assign w_rd_ok = uart_rx_ready && (r_rd_hold == 2'd0);

  always_comb begin
    w_next      = r_state;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    w_tx_byte   = 8'h00;
    w_pld_rdy   = 1'b0;
    w_start_ok  = 1'b0;
    w_len_dec   = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_inc   = 1'b0;
    w_retry_inc = 1'b0;
    w_err_set   = 1'b0;
    w_err_val   = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_ok = 1'b1;
          w_next     = S_INIT;
        end
      end
      S_INIT: begin
        w_next = S_SEND_STX;
      end
      S_SEND_STX: begin
        w_rd = w_rd_ok;
        if (w_wr_ok) begin
          w_wr      = 1'b1;
          w_tx_byte = CH_STX;
          w_next    = (r_len_cnt == '0) ? S_SEND_ETX : S_SEND_DATA;
        end
      end
      S_SEND_DATA: begin
        w_rd = w_rd_ok;
        if (w_wr_ok && pld_valid) begin
          w_wr      = 1'b1;
          w_tx_byte = pld_data;
          w_pld_rdy = 1'b1;
          w_len_dec = 1'b1;
          if (r_len_cnt == LEN_W'(1)) begin
            w_next = S_SEND_ETX;
          end
        end
      end
      S_SEND_ETX: begin
        w_rd = w_rd_ok;
        if (w_wr_ok) begin
          w_wr      = 1'b1;
          w_tx_byte = CH_ETX;
          w_tmr_clr = 1'b1;
          w_next    = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        w_rd      = w_rd_ok;
        w_tmr_inc = 1'b1;
        // a response byte in the expiry cycle takes priority over the timeout
        if (w_rd_ok && (uart_rx_data == CH_ACK)) begin
          w_next = S_DONE;
        end else if (w_rd_ok && (uart_rx_data == CH_EOT)) begin
          w_err_set = 1'b1;
          w_err_val = 2'd2;
          w_next    = S_ERR;
        end else if (r_timer == TOUT_LAST) begin
          if (r_retry < RETRY_MAX) begin
            w_retry_inc = 1'b1;
            w_next      = S_SEND_ENQ;
          end else begin
            w_err_set = 1'b1;
            w_err_val = 2'd1;
            w_next    = S_ERR;
          end
        end
      end
      S_SEND_ENQ: begin
        w_rd = w_rd_ok;
        if (w_wr_ok) begin
          w_wr      = 1'b1;
          w_tx_byte = CH_ENQ;
          w_tmr_clr = 1'b1;
          w_next    = S_WAIT_RSP;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len_cnt  <= '0;
      r_timer    <= '0;
      r_retry    <= '0;
      r_err_code <= 2'd0;
      r_uart_en  <= 1'b0;
      r_wr_hold  <= 2'd0;
      r_rd_hold  <= 2'd0;
    end else begin
      if (w_start_ok) begin
        r_len_cnt  <= len;
        r_retry    <= '0;
        r_err_code <= 2'd0;
      end else if (w_len_dec) begin
        r_len_cnt <= r_len_cnt - LEN_W'(1);
      end

      if (w_tmr_clr) begin
        r_timer <= '0;
      end else if (w_tmr_inc) begin
        r_timer <= r_timer + TOUT_W'(1);
      end

      if (w_retry_inc) begin
        r_retry <= r_retry + RW'(1);
      end

      if (w_err_set) begin
        r_err_code <= w_err_val;
      end

      // enables rise the cycle after the soft-reset pulse and stay up until reset
      if (r_state == S_INIT) begin
        r_uart_en <= 1'b1;
      end

      if (w_wr) begin
        r_wr_hold <= 2'd2;
      end else if (r_wr_hold != 2'd0) begin
        r_wr_hold <= r_wr_hold - 2'd1;
      end

      if (w_rd) begin
        r_rd_hold <= 2'd2;
      end else if (r_rd_hold != 2'd0) begin
        r_rd_hold <= r_rd_hold - 2'd1;
      end
    end
  end

  assign pld_ready          = w_pld_rdy;
  assign busy               = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
  assign done               = (r_state == S_DONE);
  assign error              = (r_state == S_ERR);
  assign err_code           = r_err_code;
  assign uart_rst_soft      = (r_state == S_INIT);
  assign uart_tx_en         = r_uart_en;
  assign uart_rx_en         = r_uart_en;
  assign uart_bit_duration  = DIV_W'(DIV);
  assign uart_tx_data       = w_tx_byte;
  assign uart_data_write_en = w_wr;
  assign uart_data_read_en  = w_rd;

endmodule

// File: doc/uart_xfer_ctrl.md
Name: uart_xfer_ctrl

Overview:
- Backend sequencer for uart_core: drives its soft reset, enables, write/read strobes and bit_duration.
- Sends one framed packet per `start`: STX (0x02), LEN payload bytes pulled from a valid/ready source, ETX (0x03).
- Then waits for ACK (0x06) from the far end; on timeout it sends ENQ (0x05) up to MAX_RETRY times.
- Sits between the system-side packet source and uart_core in the UART subsystem.

Parameters:
- DIV_W, 16, width of uart_bit_duration.
- DIV, 100, clocks per bit driven on uart_bit_duration (constant).
- LEN_W, 8, payload length field width.
- TOUT_W, 24, timeout counter width.
- TIMEOUT, 100000, clocks to wait for a response before ENQ/error.
- MAX_RETRY, 3, ENQ attempts before giving up.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-low reset.
- start, in, 1, begin transaction; sampled only in IDLE.
- len, in, LEN_W, payload byte count, latched at start; 0 allowed.
- pld_valid, in, 1, payload byte available.
- pld_data, in, 8, payload byte.
- pld_ready, out, 1, payload byte consumed this cycle.
- busy, out, 1, high from the cycle after an accepted start until done/error.
- done, out, 1, one-cycle pulse: ACK received.
- error, out, 1, one-cycle pulse: transaction failed.
- err_code, out, 2, 0 none, 1 retries exhausted, 2 EOT abort; held until next start.
- uart_rst_soft, out, 1, soft reset pulse to uart_core.
- uart_tx_en, out, 1, uart_core tx enable.
- uart_rx_en, out, 1, uart_core rx enable.
- uart_bit_duration, out, DIV_W, constant DIV.
- uart_tx_data, out, 8, byte to send.
- uart_data_write_en, out, 1, write strobe.
- uart_tx_ready, in, 1, uart_core can accept a byte.
- uart_rx_data, in, 8, received byte.
- uart_rx_ready, in, 1, received byte pending.
- uart_data_read_en, out, 1, read strobe.

Behaviour:

Reset (rst=0 at a clk edge):
- All outputs 0 except uart_bit_duration=DIV.
- State IDLE; counters and err_code cleared.
- Reset mid-transaction aborts it immediately; no done/error pulse is issued.

States:
- IDLE: start=1 latches len, clears err_code and the retry count, and goes to INIT.
- INIT: uart_rst_soft=1 for exactly one cycle. Next cycle uart_tx_en and uart_rx_en go to 1; they stay 1 until reset. Then SEND_STX.
- SEND_STX: write 0x02. Then SEND_DATA, or SEND_ETX if len==0.
- SEND_DATA: the byte counter counts down from len.
  - pld_ready=1 only in a cycle where pld_valid=1 and a write is issued.
  - That byte is driven on uart_tx_data in the same cycle.
  - After the last byte, go to SEND_ETX.
- SEND_ETX: write 0x03, then WAIT_RSP with the timer cleared.
- WAIT_RSP: timer increments each cycle.
  - Byte 0x06 → DONE.
  - Byte 0x04 → error with code 2.
  - Any other byte is consumed and discarded; the timer is not reset.
  - Timer reaching TIMEOUT-1 with retries<MAX_RETRY → SEND_ENQ, retries+1.
  - Timer reaching TIMEOUT-1 with retries==MAX_RETRY → error with code 1.
- SEND_ENQ: write 0x05, then WAIT_RSP with the timer cleared.
- DONE / ERR: one-cycle done or error pulse, busy drops in the same cycle, return to IDLE.

Write rule:
- A write is a single-cycle uart_data_write_en=1 with uart_tx_data valid, issued only when uart_tx_ready=1.
- After a write at cycle W, uart_tx_ready is ignored through W+2; the next write is no earlier than W+3.

Read rule:
- A read is a single-cycle uart_data_read_en=1 when uart_rx_ready=1, capturing uart_rx_data in the same cycle.
- The same 2-cycle holdoff applies before uart_rx_ready is sampled again.
- In send states, pending rx bytes are drained and discarded. Reads and writes may occur in the same cycle.

Boundary conditions:
- start while busy is ignored.
- pld_valid low stalls SEND_DATA indefinitely; there is no timeout in send states.
- An ACK arriving in the same cycle as the timer expiry wins, giving done.
- len is treated as unsigned; 2^LEN_W-1 is the maximum.

Test Plan:
- Bench uses a far-end UART model at DIV=100.
- len=3, payload 0x41,0x42,0x43, model replies 0x06 → line carries 02 41 42 43 03. Exactly 3 pld_ready pulses, one uart_rst_soft pulse, done pulse, err_code=0.
- len=0, reply 0x06 → line carries 02 03 only, zero pld_ready pulses, done.
- No reply, TIMEOUT=2000, MAX_RETRY=2 → 02 .. 03, then 05 after 2000 clocks, and again after a further 2000. Error pulse 2000 clocks after the second 05, err_code=1, busy=0.
- Reply 0x15 then 0x06 → 0x15 consumed via uart_data_read_en, done pulse, no ENQ sent.
- Reply 0x04 → error pulse, err_code=2. The next start runs normally and clears err_code.
- rst=0 while sending the 2nd of 5 payload bytes → all outputs at reset values next cycle. start asserted during busy is ignored. A new start after reset completes normally.
